signal_delay_line: RTL

Parametrised, runtime-programmable delay line for multi-bit audio control and data signals, with per-sample valid tracking, clock-enable stalling and a fill/realign state machine. It is the general replacement for fixed single-bit enable delays. It sits between the audio front end and the PCM datapath, aligning strobes such as `audio_en` against `*_pcm_d_en` and data words whose pipeline depth varies with the selected mode.

---
 rtl/signal_delay_pkg.sv | 27 ++
 rtl/signal_delay_stage.sv | 38 +++
 rtl/signal_delay_line.sv | 116 +++++++++++
 3 files changed

// File: rtl/signal_delay_pkg.sv
// Shared types and helpers for the signal_delay_line delay block.
package signal_delay_pkg;

    typedef enum logic [0:0] {
        SD_FILL = 1'b0,
        SD_RUN  = 1'b1
    } sd_state_t;

    localparam int SD_MIN_DLY = 1;

    // Width of the delay-select field: must encode 0..max_dly.
    function automatic int sd_dly_w(input int max_dly);
        return $clog2(max_dly + 1);
    endfunction

    // Fill counter only ever needs to reach max_dly-1; keep at least one bit.
    function automatic int sd_cnt_w(input int max_dly);
        return (max_dly > 1) ? $clog2(max_dly) : 1;
    endfunction

    function automatic int sd_clamp_dly(input int sel, input int max_dly);
        if (sel < SD_MIN_DLY) return SD_MIN_DLY;
        if (sel > max_dly)    return max_dly;
        return sel;
    endfunction

endpackage

// File: rtl/signal_delay_stage.sv
// One {valid, data} delay stage with clock enable; optional valid clear
// on `flush` when SIGNAL_DELAY_FLUSH_EN is defined.
module signal_delay_stage
    import signal_delay_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce,
`ifdef SIGNAL_DELAY_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             vld_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             vld_out,
    output logic [WIDTH-1:0] data_out
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_out  <= 1'b0;
            data_out <= '0;
        end else begin
            if (ce) begin
                vld_out  <= vld_in;
                data_out <= data_in;
            end
`ifdef SIGNAL_DELAY_FLUSH_EN
            // Flush wins over a simultaneous shift; data is left in place.
            if (flush) begin
                vld_out <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: rtl/signal_delay_line.sv
// Runtime-programmable delay line with valid tracking, ce stalling and a
// fill/realign FSM. Define SIGNAL_DELAY_FLUSH_EN to add the `flush` input.
module signal_delay_line
    import signal_delay_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int MAX_DLY     = 8,
    parameter int DEFAULT_DLY = 3
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         ce,
`ifdef SIGNAL_DELAY_FLUSH_EN
    input  logic                         flush,
`endif
    input  logic [$clog2(MAX_DLY+1)-1:0] dly_sel,
    input  logic [WIDTH-1:0]             data_in,
    input  logic                         valid_in,
    output logic [WIDTH-1:0]             data_out,
    output logic                         valid_out,
    output logic                         locked
);

    localparam int DLY_W = sd_dly_w(MAX_DLY);
    localparam int CNT_W = sd_cnt_w(MAX_DLY);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             stage_vld  [MAX_DLY];
    logic [WIDTH-1:0] stage_data [MAX_DLY];
    logic [DLY_W-1:0] dly_q;
    logic [CNT_W-1:0] fill_cnt;
    logic [CNT_W-1:0] tap_idx;
    sd_state_t        state;
    logic             locked_q;
    logic             dly_change;
    int               d_cur;
    int               d_req;

    for (genvar i = 0; i < MAX_DLY; i++) begin : g_stage
        logic             vld_src;
        logic [WIDTH-1:0] data_src;

        if (i == 0) begin : g_head
            assign vld_src  = valid_in;
            assign data_src = data_in;
        end else begin : g_tail
            assign vld_src  = stage_vld[i-1];
            assign data_src = stage_data[i-1];
        end

        signal_delay_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk      (clk),
            .reset_n  (reset_n),
            .ce       (ce),
`ifdef SIGNAL_DELAY_FLUSH_EN
            .flush    (flush),
`endif
            .vld_in   (vld_src),
            .data_in  (data_src),
            .vld_out  (stage_vld[i]),
            .data_out (stage_data[i])
        );
    end

    always_comb begin
        d_cur      = sd_clamp_dly(int'(dly_q), MAX_DLY);
        d_req      = sd_clamp_dly(int'(dly_sel), MAX_DLY);
        dly_change = (d_req != d_cur);
        tap_idx    = CNT_W'(d_cur - 1);
    end

    // dly_q tracks the request every edge, stalled or not.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dly_q <= DLY_W'(DEFAULT_DLY);
        end else begin
            dly_q <= dly_sel;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= SD_FILL;
            fill_cnt <= '0;
            locked_q <= 1'b0;
        end else begin
`ifdef SIGNAL_DELAY_FLUSH_EN
            if (flush) begin
                state    <= SD_FILL;
                fill_cnt <= '0;
                locked_q <= 1'b0;
            end else
`endif
            if (dly_change) begin
                // Realign: stale stages stay, hidden by the lock mask.
                state    <= SD_FILL;
                fill_cnt <= '0;
                locked_q <= 1'b0;
            end else if (ce && state == SD_FILL) begin
                if (int'(fill_cnt) == d_cur - 1) begin
                    state    <= SD_RUN;
                    locked_q <= 1'b1;
                end else if (fill_cnt != CNT_MAX) begin
                    fill_cnt <= fill_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign data_out  = stage_data[tap_idx];
    assign valid_out = stage_vld[tap_idx] & locked_q;
    assign locked    = locked_q;

endmodule
